xgmii_rx_monitor: RTL and testbench
===================================

# xgmii_rx_monitor

Receive-side XGMII frame monitor on the 156.25 MHz XGMII clock domain. It consumes the 64-bit XGMII receive stream of network path 0 and works out frame boundaries, preamble/SFD validity and frame length. It classifies each frame as good or bad, reports it, and keeps running statistics counters. It sits between the 10GBASE-R PHY receive output and the user application, in parallel with the application's own receive logic; it never modifies data.

## Interface
Parameters:
- MIN_LEN, 64: smallest good frame length in bytes, SFD excluded, FCS included.
- MAX_LEN, 1518: largest good frame length in bytes.

Ports:
- xgmii_clk  in  1  156.25 MHz XGMII clock; all logic on rising edge.
- sys_rst_n  in  1  Reset, asynchronous, active-low.
- xgmii_rxd  in  64  Receive data; byte lane i = [8i+7:8i]; lane 0 is first on the wire.
- xgmii_rxc  in  8  Receive control; bit i flags lane i as a control character.
- link_up  in  1  PHY block lock (xphy_status[0]).
- stats_clear  in  1  Synchronous clear of all counters.
- frame_valid  out  1  One-cycle pulse: a frame report is present.
- frame_len  out  16  Byte count of the reported frame; saturates at 16'hFFFF.
- frame_err  out  1  Reported frame is bad; qualified by frame_valid.
- good_frames  out  32  Count of good frames; wraps.
- bad_frames  out  32  Count of bad frames; wraps.
- rx_bytes  out  48  Sum of frame_len over good frames; wraps.

## Operation
- Characters: START 8'hFB, TERMINATE 8'hFD, ERROR 8'hFE, IDLE 8'h07, preamble 8'h55, SFD 8'hD5.
- Lane-0 start: rxc[0]=1, lane 0 is START, lanes 1–6 are 55 with rxc=0, lane 7 is D5. Data begins at lane 0 of the next word. FSM goes IDLE→DATA.
- Lane-4 start: rxc[4]=1 and lane 4 is START. Lanes 5–7 must be 55.
  - FSM goes IDLE→PRE.
  - On the next word, lanes 0–2 must be 55 and lane 3 must be D5, with rxc[3:0]=0. Lanes 4–7 are the first 4 data bytes.
  - FSM goes PRE→DATA.
- Any preamble or SFD mismatch marks the frame bad. The FSM still enters DATA and counts to the terminate.
- DATA word without control: length += 8.
- DATA word with TERMINATE in lane k: length += k (only lanes below k count). Lanes above k are ignored. FSM goes to IDLE and the frame is reported.
- Bad-frame conditions:
  - ERROR in any data lane.
  - Any other control character before the terminate.
  - Length < MIN_LEN or > MAX_LEN.
  - Preamble or SFD error.
- START seen while in PRE or DATA:
  - Report the current frame as bad, with the length accumulated so far.
  - Begin the new frame from that START in the same cycle.
- link_up low: FSM forced to IDLE and the partial frame is discarded without a report. Counters hold.
- IDLE: any non-START word is ignored.
- Counters: good → good_frames+1 and rx_bytes+=frame_len; bad → bad_frames+1.
- stats_clear: all three counters go to 0 next cycle. Clear wins over a concurrent increment; that frame is still reported on frame_valid.

## Timing
- Reset values: all outputs 0; FSM in IDLE; length accumulator 0.
- Latency: frame_valid, frame_len and frame_err are registered. They appear 1 cycle after the word containing TERMINATE, or after the aborting START.
- Counters update on the same edge that asserts frame_valid.
- frame_len and frame_err hold their value until the next report.
- Back-to-back frames: TERMINATE in word n and START in word n+1 is supported; each frame produces one pulse.
- TERMINATE and lane-4 START in the same word:
  - Report the first frame.
  - Enter PRE for the second.
- Reset asserted mid-frame: all state is cleared immediately and asynchronously, with no report.

## Structure
- Package xgmii_pkg holds:
  - The character constants.
  - The FSM state enumeration IDLE/PRE/DATA.
  - The lane-index width.
- Sub-module xgmii_lane_decode, combinational and one instance. Per-word outputs:
  - start0 and start4.
  - term_valid and the 3-bit term_lane.
  - err_any: ERROR or an unexpected control character in the data lanes.
  - pre0_ok, pre4a_ok and pre4b_ok.
- The top holds the FSM, the length accumulator with saturation, the report registers and the counters.

## Test plan
- 64-byte frame, lane-0 start: 8 data words, then TERMINATE in lane 0 → one pulse, frame_len=64, frame_err=0, good_frames=1, rx_bytes=64.
- 67-byte frame, lane-4 start: TERMINATE lands in lane 7 → frame_len=67, good; a back-to-back second frame gives good_frames=2.
- 60-byte frame → frame_err=1, bad_frames=1, rx_bytes unchanged. 1519-byte frame → frame_err=1.
- ERROR in lane 5 mid-frame, then a new START before any TERMINATE → exactly one bad report for the first frame. The second frame then completes good.
- link_up dropped mid-frame → no pulse and counters unchanged; after link_up returns, a 64-byte frame is good.
- stats_clear in the same cycle as a good-frame report → frame_valid=1 and all counters read 0 on the next cycle.
- sys_rst_n asserted mid-frame → all outputs read 0 immediately, with no pulse.

Source files
------------

// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - XGMII character constants, FSM states and lane-index width
package xgmii_pkg;

  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_ERROR = 8'hFE;
  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_PRE   = 8'h55;
  localparam logic [7:0] CH_SFD   = 8'hD5;

  localparam int LANE_W = 3;

  // Frame FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/xgmii_lane_decode.sv
// rtl/xgmii_lane_decode.sv - per-word XGMII lane classification (combinational)
module xgmii_lane_decode
  import xgmii_pkg::*;
(
  input  logic [63:0]       rxd,
  input  logic [7:0]        rxc,
  input  logic              skip_lo,
  output logic              start0,
  output logic              start4,
  output logic              term_valid,
  output logic [LANE_W-1:0] term_lane,
  output logic              err_any,
  output logic              pre0_ok,
  output logic              pre4a_ok,
  output logic              pre4b_ok
);

  logic term_seen;

  assign start0   = rxc[0] && (rxd[7:0] == CH_START);
  assign start4   = rxc[4] && (rxd[39:32] == CH_START);
  assign pre0_ok  = (rxc[7:1] == 7'd0) && (rxd[55:8] == {6{CH_PRE}}) && (rxd[63:56] == CH_SFD);
  assign pre4a_ok = (rxc[7:5] == 3'd0) && (rxd[63:40] == {3{CH_PRE}});
  assign pre4b_ok = (rxc[3:0] == 4'd0) && (rxd[23:0] == {3{CH_PRE}}) && (rxd[31:24] == CH_SFD);

  // Lowest TERMINATE lane, and any control character in data lanes ahead of it.
  // skip_lo excludes lanes 0-3, which hold preamble/SFD on the word after a lane-4 start.
  always_comb begin
    term_valid = 1'b0;
    term_lane  = '0;
    err_any    = 1'b0;
    term_seen  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (rxc[i] && (rxd[8*i +: 8] == CH_TERM)) begin
        term_valid = 1'b1;
        term_lane  = LANE_W'(i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (rxc[i] && (rxd[8*i +: 8] == CH_TERM)) begin
        term_seen = 1'b1;
      end else if (!term_seen && rxc[i] && !(skip_lo && (i < 4))) begin
        err_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xgmii_rx_monitor.sv
// rtl/xgmii_rx_monitor.sv - XGMII receive frame monitor: framing, length, classification, statistics
module xgmii_rx_monitor
  import xgmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        xgmii_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic        link_up,
  input  logic        stats_clear,
  output logic        frame_valid,
  output logic [15:0] frame_len,
  output logic        frame_err,
  output logic [31:0] good_frames,
  output logic [31:0] bad_frames,
  output logic [47:0] rx_bytes
);

  localparam logic [15:0] MIN16 = 16'(MIN_LEN);
  localparam logic [15:0] MAX16 = 16'(MAX_LEN);

  logic [1:0]        state;
  logic [15:0]       len_acc;
  logic              pre_bad;
  logic              err_seen;

  logic              start0, start4, term_valid, err_any;
  logic              pre0_ok, pre4a_ok, pre4b_ok;
  logic [LANE_W-1:0] term_lane;

  logic              in_frame, in_pre, term_lt4, abort, end_term, new_frame, report;
  logic [3:0]        add_len;
  logic [16:0]       sum;
  logic [15:0]       len_next, rep_len;
  logic              pre_cur, rep_err;

  xgmii_lane_decode u_decode (
    .rxd        (xgmii_rxd),
    .rxc        (xgmii_rxc),
    .skip_lo    (in_pre),
    .start0     (start0),
    .start4     (start4),
    .term_valid (term_valid),
    .term_lane  (term_lane),
    .err_any    (err_any),
    .pre0_ok    (pre0_ok),
    .pre4a_ok   (pre4a_ok),
    .pre4b_ok   (pre4b_ok)
  );

  assign in_frame = (state != ST_IDLE);
  assign in_pre   = (state == ST_PRE);
  assign term_lt4 = term_valid && !term_lane[2];

  // Word classification: abort on a START not preceded by a terminate, and length bookkeeping
  always_comb begin
    abort     = in_frame && (start0 || (start4 && !term_lt4));
    end_term  = in_frame && term_valid && !abort;
    new_frame = in_frame ? (abort || (end_term && start4)) : (start0 || start4);
    report    = abort || end_term;
    if (in_pre) begin
      add_len = term_valid ? (term_lane[2] ? {2'b00, term_lane[1:0]} : 4'd0) : 4'd4;
    end else begin
      add_len = term_valid ? {1'b0, term_lane} : 4'd8;
    end
    sum      = {1'b0, len_acc} + {13'd0, add_len};
    len_next = sum[16] ? 16'hFFFF : sum[15:0];
    pre_cur  = pre_bad || (in_pre && !pre4b_ok);
    rep_len  = abort ? len_acc : len_next;
    rep_err  = abort || pre_cur || err_seen || err_any ||
               (len_next < MIN16) || (len_next > MAX16);
  end

  // Frame FSM and per-frame accumulators; link loss drops the partial frame silently
  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      len_acc  <= '0;
      pre_bad  <= 1'b0;
      err_seen <= 1'b0;
    end else if (!link_up) begin
      state    <= ST_IDLE;
      len_acc  <= '0;
      pre_bad  <= 1'b0;
      err_seen <= 1'b0;
    end else if (new_frame) begin
      state    <= start0 ? ST_DATA : ST_PRE;
      len_acc  <= '0;
      pre_bad  <= start0 ? !pre0_ok : !pre4a_ok;
      err_seen <= 1'b0;
    end else if (end_term) begin
      state    <= ST_IDLE;
      len_acc  <= '0;
      pre_bad  <= 1'b0;
      err_seen <= 1'b0;
    end else if (in_frame) begin
      state    <= ST_DATA;
      len_acc  <= len_next;
      pre_bad  <= pre_cur;
      err_seen <= err_seen || err_any;
    end
  end

  // Registered frame report; length and error hold until the next report
  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_valid <= 1'b0;
      frame_len   <= '0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= report && link_up;
      if (report && link_up) begin
        frame_len <= rep_len;
        frame_err <= rep_err;
      end
    end
  end

  // Statistics counters; clear takes priority over a concurrent increment
  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      good_frames <= '0;
      bad_frames  <= '0;
      rx_bytes    <= '0;
    end else if (stats_clear) begin
      good_frames <= '0;
      bad_frames  <= '0;
      rx_bytes    <= '0;
    end else if (report && link_up) begin
      if (rep_err) begin
        bad_frames <= bad_frames + 32'd1;
      end else begin
        good_frames <= good_frames + 32'd1;
        rx_bytes    <= rx_bytes + {32'd0, rep_len};
      end
    end
  end

endmodule

// File: tb/tb_xgmii_rx_monitor.sv
// tb/tb_xgmii_rx_monitor.sv - directed self-checking bench for xgmii_rx_monitor
module tb_xgmii_rx_monitor;

  logic        xgmii_clk = 1'b0;
  logic        sys_rst_n;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic        link_up;
  logic        stats_clear;
  logic        frame_valid;
  logic [15:0] frame_len;
  logic        frame_err;
  logic [31:0] good_frames;
  logic [31:0] bad_frames;
  logic [47:0] rx_bytes;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C = 8'hFF;
  localparam logic [63:0] SOF0_D = 64'hD5555555555555FB;
  localparam logic [7:0]  SOF0_C = 8'h01;
  localparam logic [63:0] SOF4_D = 64'h555555FB07070707;
  localparam logic [7:0]  SOF4_C = 8'h1F;
  localparam logic [63:0] PRE4_D = 64'h44332211D5555555;
  localparam logic [63:0] T2S4_D = 64'h555555FB07FDBBAA;
  localparam logic [7:0]  T2S4_C = 8'h1C;
  localparam logic [63:0] ERR5_D = 64'h1111FE1111111111;
  localparam logic [7:0]  ERR5_C = 8'h20;

  xgmii_rx_monitor #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .xgmii_clk   (xgmii_clk),
    .sys_rst_n   (sys_rst_n),
    .xgmii_rxd   (xgmii_rxd),
    .xgmii_rxc   (xgmii_rxc),
    .link_up     (link_up),
    .stats_clear (stats_clear),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_err   (frame_err),
    .good_frames (good_frames),
    .bad_frames  (bad_frames),
    .rx_bytes    (rx_bytes)
  );

  always #5 xgmii_clk = ~xgmii_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    @(negedge xgmii_clk);
    xgmii_rxd = d;
    xgmii_rxc = c;
  endtask

  task automatic data_words(input int n);
    for (int i = 0; i < n; i++) drive(64'h0123456789ABCDEF ^ 64'(i), 8'h00);
  endtask

  task automatic term_word(input int k);
    logic [63:0] d;
    logic [7:0]  c;
    for (int i = 0; i < 8; i++) begin
      if (i < k)       d[8*i +: 8] = 8'h10 + 8'(i);
      else if (i == k) d[8*i +: 8] = 8'hFD;
      else             d[8*i +: 8] = 8'h07;
    end
    c = 8'hFF << k;
    drive(d, c);
  endtask

  task automatic chk_rep(input string tag, input logic [15:0] len, input logic err,
                         input logic [31:0] g, input logic [31:0] b, input logic [47:0] by);
    chk({tag, "_valid"}, frame_valid, 1);
    chk({tag, "_len"},   frame_len, len);
    chk({tag, "_err"},   frame_err, err);
    chk({tag, "_good"},  good_frames, g);
    chk({tag, "_bad"},   bad_frames, b);
    chk({tag, "_bytes"}, rx_bytes, by);
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    xgmii_rxd   = IDLE_D;
    xgmii_rxc   = IDLE_C;
    link_up     = 1'b1;
    stats_clear = 1'b0;
    @(negedge xgmii_clk);
    @(negedge xgmii_clk);
    chk("rst_valid", frame_valid, 0);
    chk("rst_len",   frame_len, 0);
    chk("rst_err",   frame_err, 0);
    chk("rst_good",  good_frames, 0);
    chk("rst_bad",   bad_frames, 0);
    chk("rst_bytes", rx_bytes, 0);
    sys_rst_n = 1'b1;
    drive(IDLE_D, IDLE_C);
    chk("idle_quiet", frame_valid, 0);

    // A: 64-byte frame, lane-0 start
    drive(SOF0_D, SOF0_C); data_words(8); term_word(0);
    drive(IDLE_D, IDLE_C);
    chk_rep("a64", 16'd64, 1'b0, 32'd1, 32'd0, 48'd64);
    drive(IDLE_D, IDLE_C);
    chk("a64_single", frame_valid, 0);

    // B: 67-byte frame, lane-4 start, terminate in lane 7, back-to-back with C
    drive(SOF4_D, SOF4_C); drive(PRE4_D, 8'h00); data_words(7); term_word(7);
    drive(SOF0_D, SOF0_C);
    chk_rep("b67", 16'd67, 1'b0, 32'd2, 32'd0, 48'd131);
    // C: 66 bytes ending in a word that also carries a lane-4 START for D
    data_words(8);
    drive(T2S4_D, T2S4_C);
    drive(PRE4_D, 8'h00);
    chk_rep("c66", 16'd66, 1'b0, 32'd3, 32'd0, 48'd197);
    data_words(7); term_word(7);
    drive(IDLE_D, IDLE_C);
    chk_rep("d67", 16'd67, 1'b0, 32'd4, 32'd0, 48'd264);

    // E: 60-byte runt
    drive(SOF0_D, SOF0_C); data_words(7); term_word(4);
    drive(IDLE_D, IDLE_C);
    chk_rep("e60", 16'd60, 1'b1, 32'd4, 32'd1, 48'd264);

    // F: 1519-byte giant
    drive(SOF0_D, SOF0_C); data_words(189); term_word(7);
    drive(IDLE_D, IDLE_C);
    chk_rep("f1519", 16'd1519, 1'b1, 32'd4, 32'd2, 48'd264);

    // G: ERROR in lane 5, then START aborts; the new frame completes good
    drive(SOF0_D, SOF0_C); data_words(3); drive(ERR5_D, ERR5_C);
    drive(SOF0_D, SOF0_C);
    data_words(1);
    chk_rep("g_abort", 16'd32, 1'b1, 32'd4, 32'd3, 48'd264);
    data_words(1);
    chk("g_single", frame_valid, 0);
    data_words(6); term_word(0);
    drive(IDLE_D, IDLE_C);
    chk_rep("g2_64", 16'd64, 1'b0, 32'd5, 32'd3, 48'd328);

    // H: link drop mid-frame discards silently
    drive(SOF0_D, SOF0_C); data_words(3);
    link_up = 1'b0;
    data_words(1);
    link_up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_words(1);
      chk("h_no_pulse", frame_valid, 0);
    end
    term_word(0);
    drive(IDLE_D, IDLE_C);
    chk("h_no_pulse_term", frame_valid, 0);
    drive(IDLE_D, IDLE_C);
    chk("h_good_hold", good_frames, 5);
    chk("h_bad_hold",  bad_frames, 3);
    chk("h_bytes_hold", rx_bytes, 328);
    drive(SOF0_D, SOF0_C); data_words(8); term_word(0);
    drive(IDLE_D, IDLE_C);
    chk_rep("h_after", 16'd64, 1'b0, 32'd6, 32'd3, 48'd392);

    // J: stats_clear coincides with a good-frame report
    drive(SOF0_D, SOF0_C); data_words(8);
    term_word(0);
    stats_clear = 1'b1;
    drive(IDLE_D, IDLE_C);
    stats_clear = 1'b0;
    chk_rep("j_clear", 16'd64, 1'b0, 32'd0, 32'd0, 48'd0);
    drive(IDLE_D, IDLE_C);
    chk("j_good_zero", good_frames, 0);
    chk("j_valid_low", frame_valid, 0);

    // K: one more good frame so reset has non-zero state to clear
    drive(SOF0_D, SOF0_C); data_words(9); term_word(3);
    drive(IDLE_D, IDLE_C);
    chk_rep("k75", 16'd75, 1'b0, 32'd1, 32'd0, 48'd75);

    // L: asynchronous reset mid-frame
    drive(SOF0_D, SOF0_C); data_words(3);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("l_valid", frame_valid, 0);
    chk("l_len",   frame_len, 0);
    chk("l_good",  good_frames, 0);
    chk("l_bytes", rx_bytes, 0);
    @(negedge xgmii_clk);
    sys_rst_n = 1'b1;
    data_words(5); term_word(0);
    drive(IDLE_D, IDLE_C);
    chk("l_no_pulse", frame_valid, 0);
    chk("l_bad_zero", bad_frames, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
